// File: rtl/mmio_bus_decoder.sv
// Memory-mapped bus decoder: routes one core data-port access at a time to a
// base/mask-selected slave, with a ready handshake, timeout and error reporting.
module mmio_bus_decoder #(
    parameter int                      DATA_W   = 32,
    parameter int                      N_SLV    = 4,
    parameter logic [N_SLV*DATA_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*DATA_W-1:0] SLV_MASK = '0,
    parameter int                      TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_req,
    input  logic [DATA_W-1:0]       m_addr,
    input  logic                    m_wren,
    input  logic [DATA_W-1:0]       m_wrdata,
    output logic [DATA_W-1:0]       m_rddata,
    output logic                    m_ready,
    output logic                    m_err,
    output logic [N_SLV-1:0]        s_req,
    output logic [DATA_W-1:0]       s_addr,
    output logic                    s_wren,
    output logic [DATA_W-1:0]       s_wrdata,
    input  logic [N_SLV*DATA_W-1:0] s_rddata,
    input  logic [N_SLV-1:0]        s_ready,
    output logic [7:0]              err_cnt
);

    localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              hit;
    logic [SEL_W-1:0]  hit_sel;
    logic [DATA_W-1:0] hit_base;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wren_q;
    logic [DATA_W-1:0] rddata_q;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rddata;

    // Walk from the top index down so the lowest matching window wins.
    always_comb begin
        hit      = 1'b0;
        hit_sel  = '0;
        hit_base = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[i*DATA_W +: DATA_W]) == SLV_BASE[i*DATA_W +: DATA_W]) begin
                hit      = 1'b1;
                hit_sel  = SEL_W'(i);
                hit_base = SLV_BASE[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        sel_ready  = 1'b0;
        sel_rddata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready  = s_ready[i];
                sel_rddata = s_rddata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Ready takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m_req) state_nxt = hit ? ACCESS : ERR;
            ACCESS:  begin
                if (sel_ready)    state_nxt = DONE;
                else if (tmo_hit) state_nxt = ERR;
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wren_q   <= 1'b0;
            rddata_q <= '0;
            tmo_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            if (state == IDLE && m_req && hit) begin
                sel_q   <= hit_sel;
                addr_q  <= (m_addr - hit_base) >> 2;
                wdata_q <= m_wrdata;
                wren_q  <= m_wren;
                tmo_cnt <= '0;
            end
            if (state == ACCESS) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (sel_ready) rddata_q <= sel_rddata;
            end
            if (state_nxt == ERR) begin
                rddata_q <= '0;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        s_req   = '0;
        s_wren  = 1'b0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        case (state)
            ACCESS: begin
                s_req  = N_SLV'(1) << sel_q;
                s_wren = wren_q;
            end
            DONE:   m_ready = 1'b1;
            ERR:    begin
                m_ready = 1'b1;
                m_err   = 1'b1;
            end
            default: ;
        endcase
    end

    assign s_addr   = addr_q;
    assign s_wrdata = wdata_q;
    assign m_rddata = rddata_q;

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Testbench for mmio_bus_decoder: directed vector table, random traffic
// against a window-rule reference model, and reset/saturation/back-to-back corners.
module tb_mmio_bus_decoder;

    localparam int TMO = 4;
    localparam logic [127:0] BASE = {32'h10000010, 32'h10000000, 32'h10010000, 32'h00400000};
    localparam logic [127:0] MASK = {32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFC00000};

    logic         clk = 1'b0;
    logic         rst;
    logic         m_req;
    logic [31:0]  m_addr;
    logic         m_wren;
    logic [31:0]  m_wrdata;
    logic [31:0]  m_rddata;
    logic         m_ready;
    logic         m_err;
    logic [3:0]   s_req;
    logic [31:0]  s_addr;
    logic         s_wren;
    logic [31:0]  s_wrdata;
    logic [127:0] s_rddata;
    logic [3:0]   s_ready;
    logic [7:0]   err_cnt;

    mmio_bus_decoder #(
        .DATA_W(32), .N_SLV(4), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_wren(m_wren),
        .m_wrdata(m_wrdata), .m_rddata(m_rddata), .m_ready(m_ready), .m_err(m_err),
        .s_req(s_req), .s_addr(s_addr), .s_wren(s_wren), .s_wrdata(s_wrdata),
        .s_rddata(s_rddata), .s_ready(s_ready), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int ec_model = 0;

    logic [31:0] base_a [4] = '{32'h00400000, 32'h10010000, 32'h10000000, 32'h10000010};
    logic [31:0] mask_a [4] = '{32'hFFC00000, 32'hFFFF0000, 32'hFFFFFFF0, 32'hFFFFFFF0};

    typedef struct {
        logic [31:0] addr;
        logic        wren;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] rdata;
        logic [3:0]  exp_sreq;
        logic [31:0] exp_saddr;
        int          exp_acc;
        int          exp_lat;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int ref_sel(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & mask_a[i]) == base_a[i]) return i;
        return -1;
    endfunction

    // Issues one request and plays the slave; wait_n < 0 means the slave never answers.
    task automatic run_txn(input logic [31:0] addr, input logic wren, input logic [31:0] wdata,
                           input int wait_n, input logic [31:0] rdata,
                           input logic [3:0] exp_sreq, input logic [31:0] exp_saddr,
                           output int lat, output int acc, output int viol,
                           output logic err, output logic [31:0] rd, output logic [7:0] ec);
        m_req = 1'b1; m_addr = addr; m_wren = wren; m_wrdata = wdata; s_ready = '0;
        @(posedge clk); #1;
        m_req = 1'b0; m_addr = $urandom; m_wrdata = $urandom; m_wren = ~wren;
        lat = -1; acc = 0; viol = 0; err = 1'b0; rd = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (m_ready) begin
                lat = cyc; err = m_err; rd = m_rddata;
                if (s_req != 4'b0) viol++;
                break;
            end
            s_rddata = {$urandom, $urandom, $urandom, $urandom};
            s_ready  = 4'($urandom_range(0, 15)) & ~exp_sreq;
            if (s_req != 4'b0) begin
                acc++;
                if (s_req !== exp_sreq || s_addr !== exp_saddr || s_wren !== wren || s_wrdata !== wdata)
                    viol++;
                if (wait_n >= 0 && acc == wait_n + 1) begin
                    s_ready = s_ready | exp_sreq;
                    for (int k = 0; k < 4; k++)
                        if (exp_sreq[k]) s_rddata[k*32 +: 32] = rdata;
                end
            end
            @(posedge clk); #1;
        end
        s_ready = '0;
        @(posedge clk); #1;
        ec = err_cnt;
    endtask

    task automatic check_txn(input string tag, input vec_t v);
        int lat, acc, viol;
        logic err;
        logic [31:0] rd;
        logic [7:0] ec;
        run_txn(v.addr, v.wren, v.wdata, v.wait_n, v.rdata, v.exp_sreq, v.exp_saddr,
                lat, acc, viol, err, rd, ec);
        if (v.exp_err && ec_model < 255) ec_model++;
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " s_req cycles"}, acc, v.exp_acc);
        chk({tag, " slave-side signals"}, viol, 0);
        chk({tag, " m_err"}, {31'b0, err}, {31'b0, v.exp_err});
        if (v.chk_rd) chk({tag, " m_rddata"}, rd, v.exp_rd);
        chk({tag, " err_cnt"}, {24'b0, ec}, ec_model);
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic wren, input logic [31:0] wdata,
                                input int wait_n, input logic [31:0] rdata, input logic [3:0] sreq,
                                input logic [31:0] saddr, input int acc, input int lat,
                                input logic err, input logic chk_rd, input logic [31:0] rd);
        vec_t v;
        v.addr = addr; v.wren = wren; v.wdata = wdata; v.wait_n = wait_n; v.rdata = rdata;
        v.exp_sreq = sreq; v.exp_saddr = saddr; v.exp_acc = acc; v.exp_lat = lat;
        v.exp_err = err; v.chk_rd = chk_rd; v.exp_rd = rd;
        return v;
    endfunction

    // Expected behaviour derived from the window rules and the slave's wait count.
    function automatic vec_t model(input logic [31:0] addr, input logic wren, input logic [31:0] wdata,
                                   input int wait_n, input logic [31:0] rdata);
        int s = ref_sel(addr);
        if (s < 0)
            return mk(addr, wren, wdata, wait_n, rdata, 4'b0, 32'h0, 0, 1, 1'b1, 1'b1, 32'h0);
        if (wait_n >= 0 && wait_n < TMO)
            return mk(addr, wren, wdata, wait_n, rdata, 4'(1 << s), (addr - base_a[s]) >> 2,
                      wait_n + 1, wait_n + 2, 1'b0, !wren, rdata);
        return mk(addr, wren, wdata, wait_n, rdata, 4'(1 << s), (addr - base_a[s]) >> 2,
                  TMO, TMO + 1, 1'b1, 1'b1, 32'h0);
    endfunction

    vec_t tbl [6];

    initial begin
        int nr, ns, gapbad, last;
        tbl[0] = mk(32'h0040000C, 1'b0, 32'h0,        0, 32'hDEADBEEF, 4'b0001, 32'd3, 1, 2, 1'b0, 1'b1, 32'hDEADBEEF);
        tbl[1] = mk(32'h10010010, 1'b1, 32'h12345678, 2, 32'hCAFEF00D, 4'b0010, 32'd4, 3, 4, 1'b0, 1'b0, 32'h0);
        tbl[2] = mk(32'h20000000, 1'b0, 32'h0,        0, 32'h11111111, 4'b0000, 32'd0, 0, 1, 1'b1, 1'b1, 32'h0);
        tbl[3] = mk(32'h10000014, 1'b0, 32'h0,       -1, 32'h22222222, 4'b1000, 32'd1, 4, 5, 1'b1, 1'b1, 32'h0);
        tbl[4] = mk(32'h10000018, 1'b0, 32'h0,        3, 32'h0BADF00D, 4'b1000, 32'd2, 4, 5, 1'b0, 1'b1, 32'h0BADF00D);
        tbl[5] = mk(32'h10000008, 1'b1, 32'hA5A55A5A, 1, 32'h0,        4'b0100, 32'd2, 2, 3, 1'b0, 1'b0, 32'h0);

        rst = 1'b1; m_req = 1'b0; m_addr = '0; m_wren = 1'b0; m_wrdata = '0;
        s_rddata = '0; s_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset s_req", {28'b0, s_req}, 32'h0);
        chk("reset m_ready/m_err/s_wren", {29'b0, m_ready, m_err, s_wren}, 32'h0);
        chk("reset m_rddata", m_rddata, 32'h0);
        chk("reset s_addr", s_addr, 32'h0);
        chk("reset s_wrdata", s_wrdata, 32'h0);
        chk("reset err_cnt", {24'b0, err_cnt}, 32'h0);

        for (int i = 0; i < 6; i++) check_txn($sformatf("vec%0d", i), tbl[i]);

        // Reset in the second ACCESS cycle of a never-ready access.
        m_req = 1'b1; m_addr = 32'h10000014; m_wren = 1'b1; m_wrdata = 32'hA5A5A5A5;
        @(posedge clk); #1 m_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        ec_model = 0;
        chk("rst mid-access s_req", {28'b0, s_req}, 32'h0);
        chk("rst mid-access m_ready/m_err/s_wren", {29'b0, m_ready, m_err, s_wren}, 32'h0);
        chk("rst mid-access m_rddata", m_rddata, 32'h0);
        chk("rst mid-access s_addr", s_addr, 32'h0);
        chk("rst mid-access s_wrdata", s_wrdata, 32'h0);
        chk("rst mid-access err_cnt", {24'b0, err_cnt}, 32'h0);
        nr = 0;
        for (int c = 0; c < 8; c++) begin
            if (m_ready) nr++;
            @(posedge clk); #1;
        end
        chk("rst mid-access no m_ready", nr, 0);

        for (int i = 0; i < 40; i++) begin
            int k = $urandom_range(0, 4);
            logic [31:0] a = $urandom;
            int w = $urandom_range(0, 5);
            if (k < 4) a = base_a[k] | (a & ~mask_a[k]);
            check_txn($sformatf("rnd%0d", i),
                      model(a, 1'($urandom_range(0, 1)), $urandom, (w == 5) ? -1 : w, $urandom));
        end

        for (int i = 0; i < 300; i++)
            check_txn($sformatf("unmapped%0d", i), model(32'h20000000 + 32'(i * 4), 1'b0, 32'h0, 0, 32'h0));
        chk("err_cnt saturated", {24'b0, err_cnt}, 32'd255);

        // m_req held high with an always-ready slave: one access every 3 cycles.
        s_ready = 4'b1111; s_rddata = {4{32'h5A5A5A5A}};
        m_req = 1'b1; m_addr = 32'h00400000; m_wren = 1'b0;
        nr = 0; ns = 0; gapbad = 0; last = -1;
        for (int c = 0; c < 12; c++) begin
            if (m_ready) begin
                nr++;
                if (last >= 0 && c - last != 3) gapbad++;
                last = c;
            end
            if (s_req != 4'b0) ns++;
            @(posedge clk); #1;
        end
        m_req = 1'b0; s_ready = '0;
        chk("b2b m_ready pulses", nr, 4);
        chk("b2b s_req cycles", ns, 4);
        chk("b2b pulse spacing", gapbad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
